// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline hazard/control unit for the five-stage RV32 core:
//            stage enables, bubbles, registered forwarding selects and a
//            memory-wait timeout detector. Optional macro: HAZARD_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 255,
    parameter int TMO_W       = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic                  iClk,
    input  logic                  nRst,
    input  logic [REG_ADDR_W-1:0] iIdRs1,
    input  logic [REG_ADDR_W-1:0] iIdRs2,
    input  logic                  iIdRs1Used,
    input  logic                  iIdRs2Used,
    input  logic [REG_ADDR_W-1:0] iExRd,
    input  logic                  iExRegWr,
    input  logic                  iExMemRd,
    input  logic [REG_ADDR_W-1:0] iMeRd,
    input  logic                  iMeRegWr,
    input  logic                  iBrTaken,
    input  logic                  iIfBusy,
    input  logic                  iMemBusy,
    output logic                  oIfEn,
    output logic                  oIdEn,
    output logic                  oExEn,
    output logic                  oMeEn,
    output logic                  oIdFlush,
    output logic                  oExFlush,
    output logic                  oFwExS1,
    output logic                  oFwExS2,
    output logic                  oFwMeS1,
    output logic                  oFwMeS2,
    output logic                  oMemTimeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           oStallCnt,
    output logic [31:0]           oFlushCnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TIMEOUT  = 2'd2
    } state_t;

    localparam logic [REG_ADDR_W-1:0] c_regZero = '0;
    localparam logic [TMO_W-1:0]      c_cntMax  = TMO_W'(MEM_TIMEOUT);
    localparam logic [TMO_W-1:0]      c_cntOne  = TMO_W'(1);

    state_t             r_state;
    state_t             w_nextState;
    logic [TMO_W-1:0]   r_cnt;
    logic [TMO_W-1:0]   w_cntNext;
    logic               w_cntHit;
    logic               r_memTimeout;

    logic               w_exHitRs1;
    logic               w_exHitRs2;
    logic               w_meHitRs1;
    logic               w_meHitRs2;
    logic               w_loadUse;
    logic               w_fwExS1;
    logic               w_fwExS2;
    logic               w_fwMeS1;
    logic               w_fwMeS2;
    logic               r_fwExS1;
    logic               r_fwExS2;
    logic               r_fwMeS1;
    logic               r_fwMeS2;

    // ------------------------------------------------------------------
    // Dependency detection against the ID source operands
    // ------------------------------------------------------------------
    assign w_exHitRs1 = iExRegWr && (iExRd != c_regZero) && (iExRd == iIdRs1) && iIdRs1Used;
    assign w_exHitRs2 = iExRegWr && (iExRd != c_regZero) && (iExRd == iIdRs2) && iIdRs2Used;
    assign w_meHitRs1 = iMeRegWr && (iMeRd != c_regZero) && (iMeRd == iIdRs1) && iIdRs1Used;
    assign w_meHitRs2 = iMeRegWr && (iMeRd != c_regZero) && (iMeRd == iIdRs2) && iIdRs2Used;

    // A load result is not available in EX/ME yet, so it stalls instead of forwarding
    assign w_loadUse = iExMemRd && (w_exHitRs1 || w_exHitRs2);

    assign w_fwExS1 = w_exHitRs1 && !iExMemRd;
    assign w_fwExS2 = w_exHitRs2 && !iExMemRd;
    assign w_fwMeS1 = w_meHitRs1 && !w_fwExS1;
    assign w_fwMeS2 = w_meHitRs2 && !w_fwExS2;

    // ------------------------------------------------------------------
    // Memory-wait counter: saturating, cleared by any non-busy cycle
    // ------------------------------------------------------------------
    always_comb begin
        w_cntNext = '0;
        w_cntHit  = 1'b0;
        if (iMemBusy) begin
            if (r_cnt == c_cntMax) begin
                w_cntNext = r_cnt;
            end else begin
                w_cntNext = r_cnt + c_cntOne;
                w_cntHit  = ((r_cnt + c_cntOne) == c_cntMax);
            end
        end
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_cnt        <= '0;
            r_memTimeout <= 1'b0;
        end else begin
            r_cnt <= w_cntNext;
            if (w_cntHit) begin
                r_memTimeout <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next state and stage controls
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        oIfEn       = 1'b1;
        oIdEn       = 1'b1;
        oExEn       = 1'b1;
        oMeEn       = 1'b1;
        oIdFlush    = 1'b0;
        oExFlush    = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (iMemBusy) begin
                    w_nextState = w_cntHit ? ST_TIMEOUT : ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (!iMemBusy) begin
                    w_nextState = ST_RUN;
                end else if (w_cntHit) begin
                    w_nextState = ST_TIMEOUT;
                end
            end
            ST_TIMEOUT: begin
                if (!iMemBusy) begin
                    w_nextState = ST_RUN;
                end
            end
            default: begin
                w_nextState = ST_RUN;
            end
        endcase

        // Freeze beats everything: EX holds and re-presents any pending branch
        if (!nRst || iMemBusy) begin
            oIfEn = 1'b0;
            oIdEn = 1'b0;
            oExEn = 1'b0;
            oMeEn = 1'b0;
        end else if (iBrTaken) begin
            oIdFlush = 1'b1;
            oExFlush = 1'b1;
        end else if (w_loadUse) begin
            oIfEn    = 1'b0;
            oIdEn    = 1'b0;
            oExFlush = 1'b1;
        end else if (iIfBusy) begin
            oIdFlush = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding selects follow the instruction from ID into EX
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_fwExS1 <= 1'b0;
            r_fwExS2 <= 1'b0;
            r_fwMeS1 <= 1'b0;
            r_fwMeS2 <= 1'b0;
        end else if (oExEn) begin
            if (oExFlush) begin
                r_fwExS1 <= 1'b0;
                r_fwExS2 <= 1'b0;
                r_fwMeS1 <= 1'b0;
                r_fwMeS2 <= 1'b0;
            end else begin
                r_fwExS1 <= w_fwExS1;
                r_fwExS2 <= w_fwExS2;
                r_fwMeS1 <= w_fwMeS1;
                r_fwMeS2 <= w_fwMeS2;
            end
        end
    end

    assign oFwExS1     = r_fwExS1;
    assign oFwExS2     = r_fwExS2;
    assign oFwMeS1     = r_fwMeS1;
    assign oFwMeS2     = r_fwMeS2;
    assign oMemTimeout = r_memTimeout;

`ifdef HAZARD_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (wrap naturally at 2^32)
    // ------------------------------------------------------------------
    logic        w_stallEvt;
    logic        w_flushEvt;
    logic [31:0] r_stallCnt;
    logic [31:0] r_flushCnt;

    assign w_stallEvt = iMemBusy || (!iBrTaken && w_loadUse);
    assign w_flushEvt = !iMemBusy && iBrTaken;

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (w_stallEvt) begin
                r_stallCnt <= r_stallCnt + 32'd1;
            end
            if (w_flushEvt) begin
                r_flushCnt <= r_flushCnt + 32'd1;
            end
        end
    end

    assign oStallCnt = r_stallCnt;
    assign oFlushCnt = r_flushCnt;
`endif

endmodule

`default_nettype wire
